ar_decoder_n: RTL and testbench

- Parametrised read-address (AR) channel decoder for the AXI bridge.
- Registers one master AR request and routes its VALID to one of NUM_SLAVES slaves. Each slave owns a contiguous, power-of-two address region starting at 0.
- Unmapped addresses go to a built-in default slave. It returns LEN+1 read beats with RRESP=DECERR, so the master never hangs.
- Sits between the master AR port and the slave AR ports. The default slave's R channel feeds the R return mux.

---
 rtl/ar_decoder_n.sv | 158 +++++++++++++++
 tb/tb_ar_decoder_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ar_decoder_n.sv
// AXI AR-channel decoder: one-entry register slice routing VALID to the slave owning the address.
// Unmapped requests are answered by a built-in default slave with LEN+1 DECERR beats.
module ar_decoder_n #(
  parameter int NUM_SLAVES  = 2,
  parameter int REGION_LOG2 = 16,
  parameter int ID_BITS     = 4,
  parameter int IDS_BITS    = 8,
  parameter int MASTER_ID   = 0,
  parameter int ADDR_BITS   = 32,
  parameter int LEN_BITS    = 4,
  parameter int SIZE_BITS   = 3,
  parameter int DATA_BITS   = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_BITS-1:0]    ARID_M,
  input  logic [ADDR_BITS-1:0]  ARADDR_M,
  input  logic [LEN_BITS-1:0]   ARLEN_M,
  input  logic [SIZE_BITS-1:0]  ARSIZE_M,
  input  logic [1:0]            ARBURST_M,
  input  logic                  ARVALID_M,
  output logic                  ARREADY_M,
  output logic [IDS_BITS-1:0]   ARID_S,
  output logic [ADDR_BITS-1:0]  ARADDR_S,
  output logic [LEN_BITS-1:0]   ARLEN_S,
  output logic [SIZE_BITS-1:0]  ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic [NUM_SLAVES-1:0] ARVALID_S,
  input  logic [NUM_SLAVES-1:0] ARREADY_S,
  output logic [IDS_BITS-1:0]   RID_E,
  output logic [DATA_BITS-1:0]  RDATA_E,
  output logic [1:0]            RRESP_E,
  output logic                  RLAST_E,
  output logic                  RVALID_E,
  input  logic                  RREADY_E
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int MID_W = IDS_BITS - ID_BITS;
  localparam logic [MID_W-1:0] MID = MID_W'(MASTER_ID);

  typedef enum logic {E_IDLE, E_RESP} e_state_t;

  logic                 r_full;
  logic                 r_err;
  logic [SEL_W-1:0]     r_sel;
  logic [ID_BITS-1:0]   r_id;
  logic [ADDR_BITS-1:0] r_addr;
  logic [LEN_BITS-1:0]  r_len;
  logic [SIZE_BITS-1:0] r_size;
  logic [1:0]           r_burst;

  e_state_t             r_state;
  logic [LEN_BITS-1:0]  r_cnt;
  logic [IDS_BITS-1:0]  r_rid;

  e_state_t             w_state_nxt;
  logic [LEN_BITS-1:0]  w_cnt_nxt;
  logic [IDS_BITS-1:0]  w_rid_nxt;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_map;
  logic                 w_pop_map;
  logic                 w_pop_err;
  logic                 w_pop;
  logic                 w_push;

  assign w_idx = ARADDR_M >> REGION_LOG2;
  assign w_map = (w_idx < ADDR_BITS'(NUM_SLAVES));

  always_comb begin
    ARVALID_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ARVALID_S[i] = r_full & ~r_err & (r_sel == SEL_W'(i));
    end
  end

  assign w_pop_map = |(ARVALID_S & ARREADY_S);
  assign w_pop_err = r_full & r_err & (r_state == E_IDLE);
  assign w_pop     = w_pop_map | w_pop_err;
  assign ARREADY_M = ~r_full | w_pop;
  assign w_push    = ARVALID_M & ARREADY_M;

  // A push in the same cycle as a pop simply overwrites the entry.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_sel   <= '0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (w_push) begin
      r_full  <= 1'b1;
      r_err   <= ~w_map;
      r_sel   <= w_idx[SEL_W-1:0];
      r_id    <= ARID_M;
      r_addr  <= ARADDR_M;
      r_len   <= ARLEN_M;
      r_size  <= ARSIZE_M;
      r_burst <= ARBURST_M;
    end else if (w_pop) begin
      r_full  <= 1'b0;
    end
  end

  assign ARID_S    = {MID, r_id};
  assign ARADDR_S  = r_addr;
  assign ARLEN_S   = r_len;
  assign ARSIZE_S  = r_size;
  assign ARBURST_S = r_burst;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= E_IDLE;
      r_cnt   <= '0;
      r_rid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rid   <= w_rid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rid_nxt   = r_rid;
    RVALID_E    = 1'b0;
    RRESP_E     = 2'b00;
    RLAST_E     = 1'b0;
    RDATA_E     = '0;
    case (r_state)
      E_IDLE: begin
        if (w_pop_err) begin
          w_state_nxt = E_RESP;
          w_cnt_nxt   = r_len;
          w_rid_nxt   = {MID, r_id};
        end
      end
      E_RESP: begin
        RVALID_E = 1'b1;
        RRESP_E  = 2'b11;
        RLAST_E  = (r_cnt == '0);
        if (RREADY_E) begin
          if (r_cnt == '0) w_state_nxt = E_IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = E_IDLE;
    endcase
  end

  assign RID_E = r_rid;

endmodule

// File: tb/tb_ar_decoder_n.sv
// Directed-vector bench for ar_decoder_n with default parameters (2 slaves, 64 KiB regions).
module tb_ar_decoder_n;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  ARID_M = '0;
  logic [31:0] ARADDR_M = '0;
  logic [3:0]  ARLEN_M = '0;
  logic [2:0]  ARSIZE_M = '0;
  logic [1:0]  ARBURST_M = '0;
  logic        ARVALID_M = 1'b0;
  logic        ARREADY_M;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic [1:0]  ARVALID_S;
  logic [1:0]  ARREADY_S = '0;
  logic [7:0]  RID_E;
  logic [31:0] RDATA_E;
  logic [1:0]  RRESP_E;
  logic        RLAST_E;
  logic        RVALID_E;
  logic        RREADY_E = 1'b0;

  int checks = 0;
  int errors = 0;

  ar_decoder_n dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_E(RID_E), .RDATA_E(RDATA_E), .RRESP_E(RRESP_E), .RLAST_E(RLAST_E),
    .RVALID_E(RVALID_E), .RREADY_E(RREADY_E)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
    ARADDR_M  = addr;
    ARID_M    = id;
    ARLEN_M   = len;
    ARSIZE_M  = 3'd2;
    ARBURST_M = 2'b01;
    ARVALID_M = 1'b1;
  endtask

  // Single mapped request with the given slave-ready pattern; entry pops on the first edge it is visible.
  task automatic send_map(input logic [31:0] addr, input logic [3:0] id,
                          input logic [1:0] rdy, input logic [1:0] exp_vld);
    ARREADY_S = rdy;
    drive_req(addr, id, 4'd1);
    #1;
    check("map_rdy_m_pre", ARREADY_M, 1'b1);
    tick();
    ARVALID_M = 1'b0;
    check("map_vld_s", ARVALID_S, exp_vld);
    check("map_id_s", ARID_S, {4'h0, id});
    check("map_addr_s", ARADDR_S, addr);
    check("map_rdy_m_post", ARREADY_M, 1'b1);
    tick();
    check("map_vld_s_clr", ARVALID_S, 2'b00);
  endtask

  task automatic collect_err(input logic [7:0] eid, input int nb, input bit toggle);
    int got;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < nb; cyc++) begin
      tick();
      RREADY_E = toggle ? ~RREADY_E : 1'b1;
      #1;
      if (RVALID_E && RREADY_E) begin
        got++;
        check("err_rid", RID_E, eid);
        check("err_rresp", RRESP_E, 2'b11);
        check("err_rdata", RDATA_E, 32'h0);
        check("err_rlast", RLAST_E, (got == nb));
        check("err_no_slv_vld", ARVALID_S, 2'b00);
      end
    end
    check("err_beats", got, nb);
    tick();
    RREADY_E = 1'b0;
    check("err_done_vld", RVALID_E, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_rdy_m", ARREADY_M, 1'b1);
    check("rst_vld_s", ARVALID_S, 2'b00);
    check("rst_addr_s", ARADDR_S, 32'h0);
    check("rst_id_s", ARID_S, 8'h0);
    check("rst_rvalid", RVALID_E, 1'b0);
    check("rst_rlast", RLAST_E, 1'b0);
    check("rst_rresp", RRESP_E, 2'b00);
    check("rst_rid", RID_E, 8'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();

    send_map(32'h0000_0004, 4'd3, 2'b01, 2'b01);
    send_map(32'h0001_FFFF, 4'd1, 2'b11, 2'b10);
    send_map(32'h0001_0000, 4'd2, 2'b11, 2'b10);
    send_map(32'h0000_FFFF, 4'd4, 2'b11, 2'b01);
    send_map(32'h0000_0000, 4'd6, 2'b11, 2'b01);

    // First unmapped address, 4 beats with RREADY_E toggling.
    ARREADY_S = 2'b11;
    drive_req(32'h0002_0000, 4'd5, 4'd3);
    tick();
    ARVALID_M = 1'b0;
    check("err_slice_vld_s", ARVALID_S, 2'b00);
    collect_err(8'h05, 4, 1'b1);

    // Maximum length burst.
    drive_req(32'hFFFF_FFF0, 4'd8, 4'hF);
    tick();
    ARVALID_M = 1'b0;
    collect_err(8'h08, 16, 1'b0);

    // Backpressure on slave 1 with a second request waiting at the master.
    ARREADY_S = 2'b00;
    drive_req(32'h0001_0000, 4'd1, 4'd2);
    tick();
    drive_req(32'h0001_0040, 4'd2, 4'd7);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rdy_m", ARREADY_M, 1'b0);
      check("bp_vld_s", ARVALID_S, 2'b10);
      check("bp_addr_s", ARADDR_S, 32'h0001_0000);
      check("bp_id_s", ARID_S, 8'h01);
      check("bp_len_s", ARLEN_S, 4'd2);
      tick();
    end
    ARREADY_S = 2'b10;
    #1;
    check("bp_rdy_m_pop", ARREADY_M, 1'b1);
    tick();
    ARVALID_M = 1'b0;
    check("bp2_vld_s", ARVALID_S, 2'b10);
    check("bp2_addr_s", ARADDR_S, 32'h0001_0040);
    check("bp2_id_s", ARID_S, 8'h02);
    check("bp2_len_s", ARLEN_S, 4'd7);
    tick();
    check("bp_empty", ARVALID_S, 2'b00);
    check("bp_empty_rdy", ARREADY_M, 1'b1);

    // Two consecutive unmapped requests: second waits in the slice.
    drive_req(32'h0003_0000, 4'd6, 4'd0);
    tick();
    drive_req(32'h8000_0000, 4'd7, 4'd1);
    #1;
    check("e2_rdy_m_first", ARREADY_M, 1'b1);
    tick();
    ARVALID_M = 1'b0;
    check("e2_rdy_m_held", ARREADY_M, 1'b0);
    check("e2_rvalid", RVALID_E, 1'b1);
    check("e2_rid_first", RID_E, 8'h06);
    collect_err(8'h06, 1, 1'b0);
    collect_err(8'h07, 2, 1'b0);
    check("e2_rdy_m_end", ARREADY_M, 1'b1);

    // Reset during the 2nd of 4 error beats.
    drive_req(32'h0004_0000, 4'd9, 4'd3);
    tick();
    ARVALID_M = 1'b0;
    tick();
    RREADY_E = 1'b1;
    tick();
    check("rm_beat2_vld", RVALID_E, 1'b1);
    check("rm_beat2_last", RLAST_E, 1'b0);
    ARESETn = 1'b0;
    #1;
    check("rm_rvalid", RVALID_E, 1'b0);
    check("rm_rdy_m", ARREADY_M, 1'b1);
    check("rm_vld_s", ARVALID_S, 2'b00);
    RREADY_E = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    check("rm_idle", RVALID_E, 1'b0);
    send_map(32'h0000_0008, 4'd4, 2'b01, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
